uart_rx_os: RTL and testbench

- Parametrised, oversampling UART receiver; successor to the single-sample receiver.
- Adds input synchronisation, majority-vote sampling, start-bit glitch rejection, valid/ready output handshake, per-frame parity/framing status, overrun and break detection.
- Sits between the FPGA rx pin and a byte consumer (FIFO or command parser).

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_os_if.sv | 27 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_os.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: state encoding, oversample tick divisor and parameter legality.
// Used by the receiver and by the transmitter that will reuse the baud tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_t;

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic bit params_ok(input int clk_hz, input int baud, input int data_bits,
                                   input int stop_bits, input int os, input int sync_stages);
    return (data_bits >= 5) && (data_bits <= 9) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (os >= 8) && ((os % 2) == 0) && (sync_stages >= 2) && (baud > 0) &&
           (tick_div(clk_hz, baud, os) >= 1);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
`timescale 1ns/1ps
// Receiver-to-consumer frame interface: valid/ready handshake plus per-frame status and pulses.
// master = receiver (drives the frame), slave = consumer (drives i_ready).
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_break;
  logic                 o_busy;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_break, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_break, o_busy,
    output i_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: one-cycle o_tick every TICK_DIV clocks.
// i_restart zeroes the phase so the next tick lands TICK_DIV cycles later.
module uart_baud_tick #(
  parameter int TICK_DIV = 10
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_restart,
  output logic o_tick
);
  import uart_pkg::*;

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap & ~i_restart;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_restart || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// Oversampling UART receiver with majority-vote sampling, glitch rejection and break detection.
// Frame is presented one cycle after the last stop-bit resolve tick; held until i_ready, else overrun.
module uart_rx_os #(
  parameter int CLOCK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE     = 9_600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 0,
  parameter int ODD_PARITY    = 1,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_rx,
  uart_rx_os_if.master rx_if
);
  import uart_pkg::*;

  localparam int             TICK_DIV  = tick_div(CLOCK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int             OSW       = $clog2(OVERSAMPLE);
  localparam int             BW        = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] T_LO      = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] T_MID     = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] T_HI      = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] T_LAST    = OSW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic           ODD       = 1'(ODD_PARITY);

  if (!params_ok(CLOCK_FREQ_HZ, BAUD_RATE, DATA_BITS, STOP_BITS, OVERSAMPLE, SYNC_STAGES)) begin : g_bad_params
    $error("uart_rx_os: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic                   r_armed;
  uart_state_t            r_state;
  logic [OSW-1:0]         r_os;
  logic                   r_s_lo;
  logic                   r_s_mid;
  logic [BW-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_stop_idx;
  logic                   r_zero;
  logic                   r_perr_acc;
  logic                   r_ferr_acc;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_overrun;
  logic                   r_break;

  logic w_rx;
  logic w_restart;
  logic w_tick;
  logic w_resolve;
  logic w_bit;

  assign w_rx      = r_sync[SYNC_STAGES-1];
  assign w_restart = (r_state == IDLE) & r_armed & r_rx_d & ~w_rx;
  assign w_resolve = w_tick & (r_os == T_HI);
  assign w_bit     = (r_s_lo & r_s_mid) | (r_s_lo & w_rx) | (r_s_mid & w_rx);

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync     <= '1;
      r_rx_d     <= 1'b1;
      r_armed    <= 1'b0;
      r_state    <= IDLE;
      r_os       <= '0;
      r_s_lo     <= 1'b1;
      r_s_mid    <= 1'b1;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_zero     <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_d    <= w_rx;
      r_armed   <= r_armed | w_rx;
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      if (r_valid && rx_if.i_ready) r_valid <= 1'b0;

      // Per-bit sample phase keeps running across bit boundaries inside a frame.
      if (w_tick && (r_state inside {START, DATA, PARITY, STOP})) begin
        r_os <= (r_os == T_LAST) ? '0 : r_os + OSW'(1);
        if (r_os == T_LO)  r_s_lo  <= w_rx;
        if (r_os == T_MID) r_s_mid <= w_rx;
      end

      case (r_state)
        IDLE: begin
          if (w_restart) begin
            r_state <= START;
            r_os    <= '0;
          end
        end
        START: begin
          if (w_resolve) begin
            if (w_bit) begin
              r_state <= IDLE;
            end else begin
              r_state    <= DATA;
              r_bit_idx  <= '0;
              r_zero     <= 1'b1;
              r_perr_acc <= 1'b0;
              r_ferr_acc <= 1'b0;
              r_stop_idx <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_resolve) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_zero  <= r_zero & ~w_bit;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_resolve) begin
            r_perr_acc <= ((^r_shift) ^ w_bit) != ODD;
            r_zero     <= r_zero & ~w_bit;
            r_state    <= STOP;
          end
        end
        STOP: begin
          if (w_resolve) begin
            if (!r_stop_idx && r_zero && !w_bit) begin
              r_break <= 1'b1;
              r_state <= BREAK_WAIT;
              r_os    <= '0;
            end else if (r_stop_idx == LAST_STOP) begin
              // Completing mid-stop-bit lets the next start edge be caught immediately.
              r_state <= IDLE;
              if (r_valid && !rx_if.i_ready) begin
                r_overrun <= 1'b1;
              end else begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
                r_perr  <= r_perr_acc;
                r_ferr  <= r_ferr_acc | ~w_bit;
              end
            end else begin
              r_ferr_acc <= r_ferr_acc | ~w_bit;
              r_stop_idx <= 1'b1;
            end
          end
        end
        BREAK_WAIT: begin
          if (!w_rx) begin
            r_os <= '0;
          end else if (w_tick) begin
            if (r_os == T_LAST) begin
              r_state <= IDLE;
              r_os    <= '0;
            end else begin
              r_os <= r_os + OSW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_if.o_data       = r_data;
  assign rx_if.o_valid      = r_valid;
  assign rx_if.o_parity_err = r_perr;
  assign rx_if.o_frame_err  = r_ferr;
  assign rx_if.o_overrun    = r_overrun;
  assign rx_if.o_break      = r_break;
  assign rx_if.o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// Bench for uart_rx_os: three receivers (8N1, 8O1, 8E1) on separate lines, a frame-level model
// predicting each presented frame and its arrival cycle, and directed checks pinning literal values.
module tb_uart_rx_os;

  localparam int CLK_HZ = 1_536_000;
  localparam int BAUD   = 9600;
  localparam int OS     = 16;
  localparam int TDIV   = 10;
  localparam int BIT    = TDIV * OS;
  localparam int SYNC   = 2;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t expq[$];

  logic [7:0] hd [3];
  logic       hp [3], hf [3], pv [3], pacc [3];
  int         rise_cyc [3], brk_cnt [3], brk_cyc [3], ovr_cnt [3];

  uart_rx_os_if #(.DATA_BITS(8)) if0 ();
  uart_rx_os_if #(.DATA_BITS(8)) if1 ();
  uart_rx_os_if #(.DATA_BITS(8)) if2 ();

  uart_rx_os #(.CLOCK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_EN(0),
               .ODD_PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC))
    u_n (.i_Clk(clk), .i_Rst(rst), .i_rx(rx0), .rx_if(if0));
  uart_rx_os #(.CLOCK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_EN(1),
               .ODD_PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC))
    u_o (.i_Clk(clk), .i_Rst(rst), .i_rx(rx1), .rx_if(if1));
  uart_rx_os #(.CLOCK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_EN(1),
               .ODD_PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC))
    u_e (.i_Clk(clk), .i_Rst(rst), .i_rx(rx2), .rx_if(if2));

  logic [7:0] v_data [3];
  logic       v_valid [3], v_perr [3], v_ferr [3], v_ovr [3], v_brk [3], v_busy [3];

  assign if0.i_ready = rdy[0];
  assign if1.i_ready = rdy[1];
  assign if2.i_ready = rdy[2];
  assign v_data[0] = if0.o_data;  assign v_data[1] = if1.o_data;  assign v_data[2] = if2.o_data;
  assign v_valid[0] = if0.o_valid; assign v_valid[1] = if1.o_valid; assign v_valid[2] = if2.o_valid;
  assign v_perr[0] = if0.o_parity_err; assign v_perr[1] = if1.o_parity_err; assign v_perr[2] = if2.o_parity_err;
  assign v_ferr[0] = if0.o_frame_err;  assign v_ferr[1] = if1.o_frame_err;  assign v_ferr[2] = if2.o_frame_err;
  assign v_ovr[0] = if0.o_overrun; assign v_ovr[1] = if1.o_overrun; assign v_ovr[2] = if2.o_overrun;
  assign v_brk[0] = if0.o_break;   assign v_brk[1] = if1.o_break;   assign v_brk[2] = if2.o_break;
  assign v_busy[0] = if0.o_busy;   assign v_busy[1] = if1.o_busy;   assign v_busy[2] = if2.o_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int dut, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s (dut%0d): got %0d, expected %0d", name, dut, act, exp_v);
    end
  endtask

  // Frame-level compare: every freshly presented frame must match the oldest prediction for that
  // receiver, arrive on the predicted cycle, and stay stable until accepted.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pv[i]   = 1'b0;
        pacc[i] = 1'b0;
      end else begin
        if (v_valid[i]) begin
          if (!pv[i] || pacc[i]) begin
            int idx;
            idx = -1;
            for (int j = 0; j < expq.size(); j++)
              if (idx < 0 && expq[j].dut == i) idx = j;
            if (idx < 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_valid (dut%0d): got data %0d, expected no frame", i, v_data[i]);
            end else begin
              chk("data", i, int'(v_data[i]), int'(expq[idx].data));
              chk("parity_err", i, int'(v_perr[i]), int'(expq[idx].perr));
              chk("frame_err", i, int'(v_ferr[i]), int'(expq[idx].ferr));
              chk("valid_rise_cycle", i, cyc, expq[idx].rise);
              expq.delete(idx);
            end
            hd[i] = v_data[i];
            hp[i] = v_perr[i];
            hf[i] = v_ferr[i];
            rise_cyc[i] = cyc;
          end else begin
            chk("hold_data", i, int'(v_data[i]), int'(hd[i]));
            chk("hold_flags", i, int'({v_perr[i], v_ferr[i]}), int'({hp[i], hf[i]}));
          end
        end
        if (v_brk[i]) begin
          brk_cnt[i]++;
          brk_cyc[i] = cyc;
        end
        if (v_ovr[i]) ovr_cnt[i]++;
        pv[i]   = v_valid[i];
        pacc[i] = v_valid[i] && rdy[i];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Serialises one frame and predicts its outcome: parity rule, stop check, break rule and the
  // arrival cycle (edge + sync + restart, then one tick past the middle-plus-one tick of the last bit).
  task automatic drive_frame(input int d, input logic [7:0] data, input bit force_pb,
                             input logic pb_val, input logic stop_v, input int spike_bit,
                             input bit deliver, output int k);
    logic wbits[$];
    logic pb, perr, brk;
    bit   pe, odd;
    exp_t e;
    pe = (d != 0);
    odd = (d != 2);
    pb = force_pb ? pb_val : ((^data) ^ odd);
    wbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) wbits.push_back(data[i]);
    if (pe) wbits.push_back(pb);
    wbits.push_back(stop_v);
    perr = pe && (((^data) ^ pb) != odd);
    brk = (data == 8'h00) && (!pe || !pb) && !stop_v;
    k = cyc;
    if (deliver && !brk) begin
      e.dut  = d;
      e.data = data;
      e.perr = perr;
      e.ferr = !stop_v;
      e.rise = k + SYNC + 1 + TDIV * (OS * (wbits.size() - 1) + OS / 2 + 2);
      expq.push_back(e);
    end
    for (int b = 0; b < wbits.size(); b++) begin
      for (int c = 0; c < BIT; c++) begin
        set_rx(d, wbits[b] ^ ((b == spike_bit && c >= 89 && c < 92) ? 1'b1 : 1'b0));
        @(posedge clk);
        #1;
      end
    end
    set_rx(d, 1'b1);
  endtask

  task automatic expect_drained(input int budget);
    for (int t = 0; t < budget && expq.size() != 0; t++) step(1);
    chk("pending_frames", -1, expq.size(), 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = 1'b1; brk_cnt[i] = 0; ovr_cnt[i] = 0; brk_cyc[i] = 0; rise_cyc[i] = 0;
    end
    @(posedge clk);
    #1;
    step(5);
    chk("rst_data", 0, int'(v_data[0]), 0);
    chk("rst_valid", 0, int'(v_valid[0]), 0);
    chk("rst_parity_err", 0, int'(v_perr[0]), 0);
    chk("rst_frame_err", 0, int'(v_ferr[0]), 0);
    chk("rst_overrun", 0, int'(v_ovr[0]), 0);
    chk("rst_break", 0, int'(v_brk[0]), 0);
    chk("rst_busy", 0, int'(v_busy[0]), 0);
    chk("rst_valid", 1, int'(v_valid[1]), 0);
    chk("rst_busy", 2, int'(v_busy[2]), 0);
    rst = 1'b0;
    step(10);

    // 8N1 0xA5: one-cycle valid, clean flags, 1543 cycles from line edge
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b1, k);
    step(20);
    chk("a5_data", 0, int'(hd[0]), 8'hA5);
    chk("a5_latency", 0, rise_cyc[0] - k, 1543);
    chk("a5_valid_dropped", 0, int'(v_valid[0]), 0);
    expect_drained(10);

    // parity: 8O1 correct (0), forced wrong, then 8E1 with parity bit 1
    drive_frame(1, 8'h91, 1'b1, 1'b0, 1'b1, -1, 1'b1, k);
    step(20);
    chk("o91_perr", 1, int'(hp[1]), 0);
    chk("o91_latency", 1, rise_cyc[1] - k, 1703);
    drive_frame(1, 8'h91, 1'b1, 1'b1, 1'b1, -1, 1'b1, k);
    step(20);
    chk("o91_bad_perr", 1, int'(hp[1]), 1);
    drive_frame(2, 8'h91, 1'b1, 1'b1, 1'b1, -1, 1'b1, k);
    step(20);
    chk("e91_perr", 2, int'(hp[2]), 0);
    expect_drained(10);

    // 20-cycle start glitch is rejected within a bit time
    set_rx(0, 1'b0);
    step(20);
    set_rx(0, 1'b1);
    step(10);
    chk("glitch_busy_seen", 0, int'(v_busy[0]), 1);
    step(130);
    chk("glitch_busy_cleared", 0, int'(v_busy[0]), 0);

    // 3-cycle spike on the middle sample of data bit 3 is outvoted
    drive_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b1, k);
    step(20);
    chk("spike_data", 0, int'(hd[0]), 0);
    expect_drained(10);

    // back-to-back frames with the consumer stalled
    rdy[0] = 1'b0;
    drive_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, 1'b1, k);
    drive_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 1'b0, k);
    step(20);
    chk("overrun_pulses", 0, ovr_cnt[0], 1);
    chk("overrun_kept_valid", 0, int'(v_valid[0]), 1);
    chk("overrun_kept_data", 0, int'(v_data[0]), 8'h11);
    rdy[0] = 1'b1;
    step(3);
    chk("overrun_accepted", 0, int'(v_valid[0]), 0);

    // break: line low for 12 bit times
    set_rx(0, 1'b0);
    k = cyc;
    step(12 * BIT);
    chk("break_pulses", 0, brk_cnt[0], 1);
    chk("break_cycle", 0, brk_cyc[0] - k, 1543);
    chk("break_wait_busy", 0, int'(v_busy[0]), 1);
    set_rx(0, 1'b1);
    step(400);
    chk("break_exit_busy", 0, int'(v_busy[0]), 0);
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 1'b1, k);
    step(20);
    chk("post_break_data", 0, int'(hd[0]), 8'h3C);
    expect_drained(10);

    // stop bit low on 0x55
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b1, k);
    step(20);
    chk("ferr_flag", 0, int'(hf[0]), 1);
    expect_drained(10);

    // reset in the middle of the data bits
    set_rx(0, 1'b0);
    step(400);
    chk("mid_frame_busy", 0, int'(v_busy[0]), 1);
    rst = 1'b1;
    step(2);
    chk("mid_rst_busy", 0, int'(v_busy[0]), 0);
    chk("mid_rst_valid", 0, int'(v_valid[0]), 0);
    chk("mid_rst_data", 0, int'(v_data[0]), 0);
    chk("mid_rst_flags", 0, int'({v_perr[0], v_ferr[0], v_ovr[0], v_brk[0]}), 0);
    rst = 1'b0;
    set_rx(0, 1'b1);
    step(20);
    drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1, 1'b1, k);
    step(20);
    chk("post_rst_data", 0, int'(hd[0]), 8'h5A);
    expect_drained(10);
    chk("stray_overrun", 0, ovr_cnt[0], 1);
    chk("stray_break", 0, brk_cnt[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
